// File: rtl/req_gnt_responder_pkg.sv
// Shared types and constants for the req/gnt responder slice.
package req_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam int LAT_W         = 8;
    localparam int DEF_GNT_CNT_W = 16;
    localparam int DEF_ERR_CNT_W = 8;

    // Wait-counter load value: WAIT spends (lat-1) sampling edges, counting down to zero.
    function automatic logic [LAT_W-1:0] wait_load(input int lat);
        if (lat < 2) return '0;
        return LAT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/req_gnt_responder_if.sv
// Request/grant handshake bundle between a requester (master) and the responder (slave).
// Handshake: req rises and is held until gnt is seen; gnt is a one-cycle pulse; a drop before gnt is an abort.
interface req_gnt_responder_if
    import req_gnt_pkg::*;
#(
    parameter int GNT_CNT_W = DEF_GNT_CNT_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
    logic                 req;
    logic                 gnt;
    logic                 busy;
    logic                 abort_err;
    logic [GNT_CNT_W-1:0] gnt_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output req,
        input  gnt, busy, abort_err, gnt_cnt, err_cnt
    );

    modport slave (
        input  req,
        output gnt, busy, abort_err, gnt_cnt, err_cnt
    );
endinterface

// File: rtl/req_gnt_responder_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/req_gnt_responder.sv
// Responder end of the req/gnt handshake: one-cycle gnt GNT_LATENCY cycles after req, abort detection, counters.
// Optional self-checking immediate assertions are compiled when RESP_ASSERT_EN is defined.
module req_gnt_responder
    import req_gnt_pkg::*;
#(
    parameter int GNT_LATENCY = 3,
    parameter int GNT_CNT_W   = DEF_GNT_CNT_W,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    req_gnt_responder_if.slave  bus,
    output state_e              dbg_state
);
    localparam logic [LAT_W-1:0] LAT_LOAD = wait_load(GNT_LATENCY);

    state_e           state, next_state;
    logic [LAT_W-1:0] cnt, next_cnt;
    logic             grant_evt, abort_evt;
    logic             gnt_q, abort_q, busy_q;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        grant_evt  = 1'b0;
        abort_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (GNT_LATENCY == 1) begin
                        next_state = GRANT;
                    end else begin
                        next_cnt   = LAT_LOAD;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // A drop on the expiry edge still wins over the grant.
                if (!bus.req) begin
                    abort_evt  = 1'b1;
                    next_state = IDLE;
                end else if (cnt == '0) begin
                    next_state = GRANT;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            GRANT: begin
                grant_evt  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            gnt_q   <= grant_evt;
            abort_q <= abort_evt;
            busy_q  <= (next_state != IDLE);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.abort_err = abort_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state;

    sat_counter #(.W(GNT_CNT_W)) u_gnt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_evt),
        .count (bus.gnt_cnt)
    );

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (abort_evt),
        .count (bus.err_cnt)
    );

`ifdef RESP_ASSERT_EN
    state_e               last_state_q;
    logic [GNT_CNT_W-1:0] last_gnt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_state_q   <= IDLE;
            last_gnt_cnt_q <= '0;
        end else begin
            last_state_q   <= state;
            last_gnt_cnt_q <= bus.gnt_cnt;
            if (gnt_q) begin
                assert (last_state_q == GRANT)
                    else $error("gnt high without a preceding GRANT state");
            end
            assert (!(gnt_q && abort_q))
                else $error("gnt and abort_err high together");
            assert (bus.gnt_cnt >= last_gnt_cnt_q)
                else $error("gnt_cnt decreased");
            assert (busy_q == (state != IDLE))
                else $error("busy disagrees with state");
        end
    end

    initial begin
        assert (GNT_LATENCY >= 1 && GNT_LATENCY <= 255)
            else $error("GNT_LATENCY %0d outside 1..255", GNT_LATENCY);
    end
`else
`endif

endmodule

// File: tb/tb_req_gnt_responder.sv
// Bench for req_gnt_responder: two instances (latency 3 / 16-bit count, latency 1 / 2-bit count) share req.
module tb_req_gnt_responder;
  import req_gnt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_drv = 1'b0;
  state_e dbg_a, dbg_b;

  always #5 clk = ~clk;

  req_gnt_responder_if #(.GNT_CNT_W(16), .ERR_CNT_W(8)) if_a ();
  req_gnt_responder_if #(.GNT_CNT_W(2),  .ERR_CNT_W(8)) if_b ();
  assign if_a.req = req_drv;
  assign if_b.req = req_drv;

  req_gnt_responder #(.GNT_LATENCY(3), .GNT_CNT_W(16), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state(dbg_a)
  );
  req_gnt_responder #(.GNT_LATENCY(1), .GNT_CNT_W(2), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state(dbg_b)
  );

  // Reference model: a request accepted at edge s grants at edge s+lat; any low req seen
  // on edges s+1..s+lat-1 aborts it. Counters saturate at their maximum.
  int lat[2]  = '{3, 1};
  int gmax[2] = '{65535, 3};
  int emax[2] = '{255, 255};
  bit m_act[2];
  int m_start[2];
  int m_g[2];
  int m_e[2];
  bit e_gnt[2], e_abort[2], e_busy[2];
  int edge_n = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  function automatic logic [26:0] obs(input int i);
    if (i == 0) return {if_a.gnt, if_a.busy, if_a.abort_err, if_a.gnt_cnt, if_a.err_cnt};
    return {if_b.gnt, if_b.busy, if_b.abort_err, 14'd0, if_b.gnt_cnt, if_b.err_cnt};
  endfunction

  function automatic logic [26:0] expv(input int i);
    return {e_gnt[i], e_busy[i], e_abort[i], 16'(m_g[i]), 8'(m_e[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_start[i] = 0; m_g[i] = 0; m_e[i] = 0;
      e_gnt[i] = 0; e_abort[i] = 0; e_busy[i] = 0;
    end
  endtask

  // Advance one rising edge, update the model with the req value sampled there, settle 1ns.
  task automatic tick();
    bit r;
    r = req_drv;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      e_gnt[i] = 0;
      e_abort[i] = 0;
      if (m_act[i]) begin
        if (edge_n == m_start[i] + lat[i]) begin
          e_gnt[i] = 1;
          m_act[i] = 0;
          if (m_g[i] < gmax[i]) m_g[i]++;
        end else if (!r) begin
          e_abort[i] = 1;
          m_act[i] = 0;
          if (m_e[i] < emax[i]) m_e[i]++;
        end
      end else if (r) begin
        m_act[i] = 1;
        m_start[i] = edge_n;
      end
      e_busy[i] = m_act[i];
    end
    #1;
  endtask

  task automatic idle_ticks(input int n);
    req_drv = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL idle dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_drv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expv(i)) begin
        bad++;
        $display("FAIL reset_outputs dut=%0d got=%h exp=%h", i, obs(i), expv(i));
      end
    end
    total++;
    if (dbg_a !== IDLE || dbg_b !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d/%0d exp=%0d", dbg_a, dbg_b, IDLE);
    end
    rst_n = 1'b1;
    idle_ticks(3);
  endtask

  task automatic test_single_grant();
    int t0;
    int gnt_edge;
    gnt_edge = -1;
    req_drv = 1'b1;
    t0 = edge_n + 1;
    for (int k = 0; k < 10 && gnt_edge < 0; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL single dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
      if (if_a.gnt === 1'b1) begin
        gnt_edge = edge_n;
        req_drv = 1'b0;
      end
    end
    total++;
    if (gnt_edge != t0 + 3) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", gnt_edge, t0 + 3);
    end
    total++;
    if (if_a.gnt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL single_gnt_cnt got=%0d exp=1", if_a.gnt_cnt);
    end
    idle_ticks(5);
  endtask

  task automatic test_back_to_back();
    int t0;
    int g0;
    t0 = edge_n + 1;
    g0 = m_g[0];
    for (int n = 0; n < 5; n++) exp_q.push_back(32'(t0 + 4 * n + 3));
    req_drv = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL b2b dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
      if (if_a.gnt === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra_gnt got=%0d exp=none", edge_n);
        end else if (exp_q.pop_front() != 32'(edge_n)) begin
          bad++;
          $display("FAIL b2b_gnt_edge got=%0d exp=other", edge_n);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (if_a.gnt_cnt !== 16'(g0 + 5)) begin
      bad++;
      $display("FAIL b2b_gnt_cnt got=%0d exp=%0d", if_a.gnt_cnt, g0 + 5);
    end
    idle_ticks(6);
  endtask

  // Drop req on edge t0+drop_at (1 = mid-wait, 2 = the expiry edge).
  task automatic test_drop(input int drop_at);
    int g0, e0;
    g0 = m_g[0];
    e0 = m_e[0];
    req_drv = 1'b1;
    for (int k = 0; k <= drop_at; k++) begin
      if (k == drop_at) req_drv = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL drop%0d dut=%0d edge=%0d got=%h exp=%h", drop_at, i, edge_n, obs(i), expv(i));
        end
      end
    end
    total++;
    if (if_a.abort_err !== 1'b1 || if_a.gnt !== 1'b0 || if_a.busy !== 1'b0) begin
      bad++;
      $display("FAIL drop%0d_pulse got=%b%b%b exp=100", drop_at, if_a.abort_err, if_a.gnt, if_a.busy);
    end
    total++;
    if (if_a.err_cnt !== 8'(e0 + 1) || if_a.gnt_cnt !== 16'(g0)) begin
      bad++;
      $display("FAIL drop%0d_cnts got=%0d/%0d exp=%0d/%0d", drop_at, if_a.err_cnt, if_a.gnt_cnt, e0 + 1, g0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (if_a.gnt !== 1'b0 || if_a.abort_err !== 1'b0) begin
        bad++;
        $display("FAIL drop%0d_after edge=%0d got=%b%b exp=00", drop_at, edge_n, if_a.gnt, if_a.abort_err);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int t0;
    int gnt_edge;
    gnt_edge = -1;
    req_drv = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (if_a.gnt !== 1'b0 || if_a.busy !== 1'b0 || if_a.abort_err !== 1'b0 ||
        if_a.gnt_cnt !== 16'd0 || if_a.err_cnt !== 8'd0 || dbg_a !== IDLE) begin
      bad++;
      $display("FAIL async_reset got=%b%b%b cnt=%0d/%0d st=%0d exp=000 0/0 st=0",
               if_a.gnt, if_a.busy, if_a.abort_err, if_a.gnt_cnt, if_a.err_cnt, dbg_a);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = edge_n + 2;
    edge_n++;
    for (int k = 0; k < 8 && gnt_edge < 0; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL post_reset dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
      if (if_a.gnt === 1'b1) begin
        gnt_edge = edge_n;
        req_drv = 1'b0;
      end
    end
    total++;
    if (gnt_edge != t0 + 3) begin
      bad++;
      $display("FAIL post_reset_latency got=%0d exp=%0d", gnt_edge, t0 + 3);
    end
    idle_ticks(5);
  endtask

  task automatic test_saturation();
    int n_gnt;
    n_gnt = 0;
    rst_n = 1'b0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n++;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    exp_q.push_back(32'd3); exp_q.push_back(32'd3);
    req_drv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL sat dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
      if (if_b.gnt === 1'b1) begin
        n_gnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sat_extra_gnt got=%0d exp=none", if_b.gnt_cnt);
        end else if (32'(if_b.gnt_cnt) != exp_q[0]) begin
          bad++;
          $display("FAIL sat_gnt_cnt got=%0d exp=%0d", if_b.gnt_cnt, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    total++;
    if (n_gnt != 5) begin
      bad++;
      $display("FAIL sat_grants got=%0d exp=5", n_gnt);
    end
    exp_q.delete();
    idle_ticks(5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_drv = ($urandom_range(0, 99) < 75);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++;
          $display("FAIL random dut=%0d edge=%0d got=%h exp=%h", i, edge_n, obs(i), expv(i));
        end
      end
    end
    idle_ticks(5);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_drop(1);
    test_drop(2);
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
